// File: rtl/fifo2axi_reader.sv
// Read-only AXI4 slave that drains a standard (non-FWFT) FIFO into AXI4 read bursts.
// Address 0x00 pops the FIFO once per beat; address 0x10 returns a {full, empty} status word.
module fifo2axi_reader #(
    parameter int AXI_ADDR_WIDTH = 6,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ID_WIDTH   = 16,
    parameter int AXI_SIZE_LOG2  = 4
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [1:0]                s_axi_arburst,
    input  logic [2:0]                s_axi_arsize,
    input  logic [7:0]                s_axi_arlen,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    output logic                      s_axi_rlast,
    input  logic                      s_axi_rready,
    output logic                      fifo_rd_en,
    input  logic [AXI_DATA_WIDTH-1:0] fifo_dout,
    input  logic                      fifo_empty,
    input  logic                      fifo_full
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DATA    = 2'd3
    } state_t;

    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_FIFO   = AXI_ADDR_WIDTH'(8'h00);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STATUS = AXI_ADDR_WIDTH'(8'h10);
    localparam logic [1:0]                RESP_OKAY   = 2'b00;
    localparam logic [1:0]                RESP_SLVERR = 2'b10;

    function automatic logic addr_legal(input logic [AXI_ADDR_WIDTH-1:0] a);
        return (a == ADDR_FIFO) || (a == ADDR_STATUS);
    endfunction

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [AXI_ADDR_WIDTH-1:0] addr_r;
    logic [7:0]                len_r;
    logic [7:0]                cnt_r;
    logic                      err_r;
    logic                      popped_r;
    logic                      arready_r;
    logic [AXI_ID_WIDTH-1:0]   rid_r;
    logic [AXI_DATA_WIDTH-1:0] rdata_r;
    logic [1:0]                rresp_r;
    logic                      rvalid_r;
    logic                      rlast_r;

    logic                      ar_hs_s;
    logic                      r_hs_s;
    logic                      rd_en_s;
    logic [AXI_DATA_WIDTH-1:0] status_s;
    logic [AXI_DATA_WIDTH-1:0] cap_data_s;
    logic [1:0]                cap_resp_s;
    logic                      unused_s;

    // Burst type is irrelevant: every beat targets the same register.
    assign unused_s = ^s_axi_arburst;

    assign ar_hs_s = (state_r == ST_IDLE) & s_axi_arvalid & arready_r;
    assign r_hs_s  = (state_r == ST_DATA) & rvalid_r & s_axi_rready;

    // Pop strobe: at most one per beat, only in the single ISSUE cycle.
    always_comb begin
        rd_en_s = 1'b0;
        if ((state_r == ST_ISSUE) && (addr_r == ADDR_FIFO) && !err_r && !fifo_empty) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Beat payload selection; empty FIFO reads answer SLVERR rather than stalling.
    always_comb begin
        status_s      = '0;
        status_s[1:0] = {fifo_full, fifo_empty};
        cap_data_s    = '0;
        cap_resp_s    = RESP_OKAY;
        if (popped_r) begin
            cap_data_s = fifo_dout;
        end else if ((addr_r == ADDR_STATUS) && !err_r) begin
            cap_data_s = status_s;
        end else begin
            cap_data_s = '0;
        end
        if (err_r || ((addr_r == ADDR_FIFO) && !popped_r)) begin
            cap_resp_s = RESP_SLVERR;
        end else begin
            cap_resp_s = RESP_OKAY;
        end
    end

    // Next-state logic for the per-beat sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ar_hs_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE:   state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_DATA;
            ST_DATA: begin
                if (r_hs_s) begin
                    state_nxt_s = rlast_r ? ST_IDLE : ST_ISSUE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch, beat counter and registered R-channel outputs.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            addr_r    <= '0;
            len_r     <= 8'd0;
            cnt_r     <= 8'd0;
            err_r     <= 1'b0;
            popped_r  <= 1'b0;
            arready_r <= 1'b0;
            rid_r     <= '0;
            rdata_r   <= '0;
            rresp_r   <= 2'b00;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
        end else begin
            arready_r <= (state_nxt_s == ST_IDLE);
            if (ar_hs_s) begin
                addr_r <= s_axi_araddr;
                len_r  <= s_axi_arlen;
                rid_r  <= s_axi_arid;
                cnt_r  <= 8'd0;
                err_r  <= (s_axi_arsize != 3'(AXI_SIZE_LOG2)) | !addr_legal(s_axi_araddr);
            end
            if (state_r == ST_ISSUE) begin
                popped_r <= rd_en_s;
            end
            if (state_r == ST_CAPTURE) begin
                rdata_r  <= cap_data_s;
                rresp_r  <= cap_resp_s;
                rlast_r  <= (cnt_r == len_r);
                rvalid_r <= 1'b1;
            end else if (r_hs_s) begin
                rvalid_r <= 1'b0;
                if (!rlast_r) begin
                    cnt_r <= cnt_r + 8'd1;
                end
            end
        end
    end

    assign s_axi_arready = arready_r;
    assign s_axi_rid     = rid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rlast   = rlast_r;
    assign fifo_rd_en    = rd_en_s;

endmodule
